// File: rtl/pacman_board_store.sv
// Pac-Man board store: one 3-bit tile code per board tile, with a combinational display port,
// a registered game-logic read port, a req/ack write port, maze init after reset and food tracking.
module pacman_board_store #(
  parameter int BOARD_WIDTH  = 32,
  parameter int BOARD_LENGTH = 24,
  parameter int PAC_X0       = 16,
  parameter int PAC_Y0       = 17,
  parameter int GHOST_X0     = 16,
  parameter int GHOST_Y0     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] x,
  input  logic [5:0] y,
  output logic [2:0] board_data,
  input  logic [5:0] gl_x,
  input  logic [5:0] gl_y,
  output logic [2:0] gl_data,
  input  logic       wr_req,
  input  logic [5:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [2:0] wr_data,
  output logic       wr_ready,
  output logic       wr_ack,
  output logic       wr_err,
  output logic [9:0] food_count,
  output logic       level_clear
);

  localparam int TILES  = BOARD_WIDTH * BOARD_LENGTH;
  localparam int ADDR_W = $clog2(TILES);

  localparam logic [2:0] TILE_EMPTY  = 3'd0;
  localparam logic [2:0] TILE_FOOD   = 3'd1;
  localparam logic [2:0] TILE_WALL   = 3'd2;
  localparam logic [2:0] TILE_PACMAN = 3'd3;
  localparam logic [2:0] TILE_GHOST  = 3'd4;
  localparam logic [2:0] TILE_GHOST_FOOD = 3'd5;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [2:0]        board [TILES];

  function automatic logic is_food(input logic [2:0] t);
    return (t == TILE_FOOD) || (t == TILE_GHOST_FOOD);
  endfunction

  function automatic logic in_range(input logic [5:0] cx, input logic [5:0] cy);
    return (int'(cx) < BOARD_WIDTH) && (int'(cy) < BOARD_LENGTH);
  endfunction

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] cx, input logic [5:0] cy);
    return ADDR_W'(int'(cy) * BOARD_WIDTH + int'(cx));
  endfunction

  // Start-maze tile for the current init index (row-major walk).
  logic [2:0] init_tile;
  always_comb begin
    int ix;
    int iy;
    ix = int'(idx) % BOARD_WIDTH;
    iy = int'(idx) / BOARD_WIDTH;
    init_tile = TILE_FOOD;
    if (ix == 0 || ix == BOARD_WIDTH - 1 || iy == 0 || iy == BOARD_LENGTH - 1)
      init_tile = TILE_WALL;
    else if (ix == PAC_X0 && iy == PAC_Y0)
      init_tile = TILE_PACMAN;
    else if (ix == GHOST_X0 && iy == GHOST_Y0)
      init_tile = TILE_GHOST;
  end

  logic              disp_ok, gl_ok, wr_ok;
  logic [ADDR_W-1:0] disp_addr, gl_addr, wr_addr;
  logic [2:0]        wr_old;
  logic              accept;

  assign disp_ok   = in_range(x, y);
  assign gl_ok     = in_range(gl_x, gl_y);
  assign wr_ok     = in_range(wr_x, wr_y);
  assign disp_addr = disp_ok ? tile_addr(x, y) : '0;
  assign gl_addr   = gl_ok ? tile_addr(gl_x, gl_y) : '0;
  assign wr_addr   = wr_ok ? tile_addr(wr_x, wr_y) : '0;
  assign wr_old    = board[wr_addr];
  assign accept    = (state == S_READY) && wr_req && !wr_ack;

  assign board_data  = (state == S_READY && disp_ok) ? board[disp_addr] : TILE_EMPTY;
  assign level_clear = wr_ready && (food_count == '0);

  // Single write port shared by maze init and game-logic writes.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_wdata;
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = init_tile;
    if (!rst) begin
      if (state == S_INIT) begin
        mem_we = 1'b1;
      end else if (accept && wr_ok) begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  // NOTE: the tile array has no reset; every entry is rewritten by the init walk,
  // which keeps it mappable onto plain storage without a reset network.
  always_ff @(posedge clk) begin
    if (mem_we) board[mem_addr] <= mem_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every read in this
  // block (board, food_count, wr_ack) sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      idx        <= '0;
      wr_ready   <= 1'b0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      gl_data    <= TILE_EMPTY;
      food_count <= '0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        S_INIT: begin
          gl_data <= TILE_EMPTY;
          if (is_food(init_tile)) food_count <= food_count + 10'd1;
          if (idx == ADDR_W'(TILES - 1)) begin
            state    <= S_READY;
            wr_ready <= 1'b1;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_READY: begin
          gl_data <= gl_ok ? board[gl_addr] : TILE_EMPTY;
          if (accept) begin
            wr_ack <= 1'b1;
            if (!wr_ok) begin
              wr_err <= 1'b1;
            end else if (is_food(wr_old) && !is_food(wr_data)) begin
              if (food_count != '0) food_count <= food_count - 10'd1;
            end else if (!is_food(wr_old) && is_food(wr_data)) begin
              if (food_count != 10'(TILES)) food_count <= food_count + 10'd1;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_board_store.sv
// Self-checking bench for pacman_board_store: table of post-init tile lookups, directed
// write sequences, randomized writes against a tile-grid reference model, and reset mid-burst.
module tb_pacman_board_store;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] x, y, gl_x, gl_y, wr_x, wr_y;
  logic [2:0] wr_data;
  logic       wr_req;
  logic [2:0] board_data, gl_data;
  logic       wr_ready, wr_ack, wr_err, level_clear;
  logic [9:0] food_count;

  pacman_board_store dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .board_data (board_data),
    .gl_x       (gl_x),
    .gl_y       (gl_y),
    .gl_data    (gl_data),
    .wr_req     (wr_req),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .food_count (food_count),
    .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model [24][32];

  typedef struct {
    int tx;
    int ty;
    int exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference maze built from the board rules, independent of any init ordering.
  task automatic init_model();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++) begin
        if (c == 0 || c == 31 || r == 0 || r == 23) model[r][c] = 2;
        else if (c == 16 && r == 17) model[r][c] = 3;
        else if (c == 16 && r == 11) model[r][c] = 4;
        else model[r][c] = 1;
      end
  endtask

  function automatic int model_at(input int cx, input int cy);
    if (cx >= 32 || cy >= 24) return 0;
    return model[cy][cx];
  endfunction

  function automatic int model_food();
    int n = 0;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++)
        if (model[r][c] == 1 || model[r][c] == 5) n++;
    return n;
  endfunction

  // Pulse rst for one cycle, then count cycles until wr_ready; wr_req is left as the caller set it.
  task automatic reset_and_init(output int acks);
    int n;
    acks = 0;
    @(negedge clk);
    rst = 1'b1;
    x = 6'd5; y = 6'd5; gl_x = 6'd5; gl_y = 6'd5;
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_gl_data", gl_data, 0);
    check("rst_food_count", food_count, 0);
    check("rst_level_clear", level_clear, 0);
    rst = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (wr_ack) acks++;
      if (n == 100) begin
        check("init_board_data_zero", board_data, 0);
        check("init_gl_data_zero", gl_data, 0);
        check("init_wr_ready_low", wr_ready, 0);
      end
      if (wr_ready) break;
    end
    wr_req = 1'b0;
    check("init_cycles", n, 768);
    check("init_food_count", food_count, 658);
    init_model();
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      @(negedge clk);
      x = 6'(tbl[i].tx); y = 6'(tbl[i].ty);
      gl_x = 6'(tbl[i].tx); gl_y = 6'(tbl[i].ty);
      #1 check($sformatf("tbl_board_data_%0d_%0d", tbl[i].tx, tbl[i].ty), board_data, tbl[i].exp);
      @(negedge clk);
      check($sformatf("tbl_gl_data_%0d_%0d", tbl[i].tx, tbl[i].ty), gl_data, tbl[i].exp);
    end
  endtask

  task automatic do_write(input int wx, input int wy, input int d);
    int n;
    int old;
    bit ok;
    old = model_at(wx, wy);
    ok  = (wx < 32) && (wy < 24);
    @(negedge clk);
    wr_x = 6'(wx); wr_y = 6'(wy); wr_data = 3'(d); wr_req = 1'b1;
    x = 6'(wx); y = 6'(wy); gl_x = 6'(wx); gl_y = 6'(wy);
    #1 check("wr_pre_board_data", board_data, old);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ack && n < 8);
    check("wr_ack_latency", n, 1);
    if (ok) model[wy][wx] = d;
    check("wr_err", wr_err, ok ? 0 : 1);
    check("wr_food_count", food_count, model_food());
    check("wr_post_board_data", board_data, model_at(wx, wy));
    check("wr_same_cycle_gl_old", gl_data, old);
    wr_req = 1'b0;
  endtask

  initial begin
    int acks;
    int last_x, last_y;
    rst = 1'b0; wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    x = '0; y = '0; gl_x = '0; gl_y = '0;

    tbl[0]  = '{0, 0, 2};   tbl[1]  = '{5, 5, 1};   tbl[2]  = '{16, 17, 3};
    tbl[3]  = '{16, 11, 4}; tbl[4]  = '{40, 3, 0};  tbl[5]  = '{31, 23, 2};
    tbl[6]  = '{31, 5, 2};  tbl[7]  = '{1, 1, 1};   tbl[8]  = '{30, 22, 1};
    tbl[9]  = '{5, 24, 0};  tbl[10] = '{63, 63, 0}; tbl[11] = '{12, 23, 2};

    repeat (2) @(negedge clk);
    reset_and_init(acks);
    check("ready_level_clear", level_clear, 0);
    run_table();

    // Directed food accounting sequences.
    do_write(5, 5, 0);
    check("clear_5_5_food", food_count, 657);
    do_write(5, 5, 5);
    check("ghost_food_5_5", food_count, 658);
    do_write(5, 5, 4);
    check("ghost_5_5", food_count, 657);
    do_write(5, 5, 4);
    check("ghost_again_5_5", food_count, 657);
    do_write(33, 2, 0);
    check("oob_food_unchanged", food_count, 657);
    check("oob_wr_err_seen", wr_err, 1);

    // Randomized writes, including out-of-range addresses and codes 6/7.
    for (int i = 0; i < 150; i++)
      do_write(int'($urandom_range(35, 0)), int'($urandom_range(26, 0)), int'($urandom_range(7, 0)));
    for (int i = 0; i < 30; i++) begin
      int rx, ry;
      rx = int'($urandom_range(40, 0));
      ry = int'($urandom_range(30, 0));
      @(negedge clk);
      gl_x = 6'(rx); gl_y = 6'(ry); x = 6'(rx); y = 6'(ry);
      #1 check("rand_board_data", board_data, model_at(rx, ry));
      @(negedge clk);
      check("rand_gl_data", gl_data, model_at(rx, ry));
    end

    // Reset in the middle of a write burst with the request still held.
    do_write(3, 3, 0);
    do_write(4, 4, 0);
    @(negedge clk);
    wr_x = 6'd6; wr_y = 6'd6; wr_data = 3'd0; wr_req = 1'b1;
    reset_and_init(acks);
    check("burst_reset_no_ack", acks, 0);
    run_table();

    // Eat every food tile, then restore one.
    last_x = 0; last_y = 0;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++)
        if (model[r][c] == 1 || model[r][c] == 5) begin
          if (model_food() == 1) begin
            check("pre_last_level_clear", level_clear, 0);
          end
          do_write(c, r, 0);
          last_x = c; last_y = r;
        end
    check("level_clear_set", level_clear, 1);
    check("level_clear_food_zero", food_count, 0);
    do_write(last_x, last_y, 1);
    check("level_clear_drop", level_clear, 0);
    check("level_clear_food_one", food_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
